// File: rtl/cpe_mult_ctrl_if.sv
// Handshake bundle between the CPE environment and the kernel-multiplier sequencer.
// CPE_MULT_CTRL_KERNEL_REUSE_EN adds cfg_reuse_kernel to the bundle.
interface cpe_mult_ctrl_if #(
    parameter int WIN_CNT_W = 16
);
    logic                 cfg_start;
    logic [WIN_CNT_W-1:0] cfg_num_windows;
`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
    logic                 cfg_reuse_kernel;
`endif
    logic                 k_valid;
    logic                 k_ready;
    logic                 kernel_run;
    logic                 win_valid;
    logic                 win_ready;
    logic                 mult_run;
    logic                 psum_valid;
    logic                 busy;
    logic                 done;

    modport master (
`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
        output cfg_reuse_kernel,
`endif
        output cfg_start, cfg_num_windows, k_valid, win_valid,
        input  k_ready, kernel_run, win_ready, mult_run, psum_valid, busy, done
    );

    modport slave (
`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
        input  cfg_reuse_kernel,
`endif
        input  cfg_start, cfg_num_windows, k_valid, win_valid,
        output k_ready, kernel_run, win_ready, mult_run, psum_valid, busy, done
    );
endinterface

// File: rtl/cpe_mult_ctrl.sv
// Sequencer for one CPE kernel multiplier: kernel load, window issue, pipeline drain.
// Optional CPE_MULT_CTRL_KERNEL_REUSE_EN lets a pass skip LOAD once a kernel is resident.
module cpe_mult_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int PIPE_DEPTH  = 5,
    parameter int WIN_CNT_W   = 16
) (
    input  logic           clock,
    input  logic           reset,
    cpe_mult_ctrl_if.slave bus
);
    localparam int K2     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KCNT_W = $clog2(K2 + 1);
    localparam int DCNT_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH - 1) : 1;
    localparam int TAG_W  = PIPE_DEPTH - 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [KCNT_W-1:0]    k_cnt_q;
    logic [WIN_CNT_W-1:0] win_cnt_q;
    logic [WIN_CNT_W-1:0] num_win_q;
    logic [DCNT_W-1:0]    drain_cnt_q;
    logic [TAG_W-1:0]     tag_p;
    logic                 psum_valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic start_ok, reuse_ok, k_last, w_last, d_last;
    logic k_ready, kernel_run, win_ready, mult_run, busy_d, done_d;

    assign start_ok = bus.cfg_start && (bus.cfg_num_windows != '0);
    assign k_last   = (k_cnt_q == KCNT_W'(K2 - 1));
    assign w_last   = (win_cnt_q == (num_win_q - WIN_CNT_W'(1)));
    assign d_last   = (drain_cnt_q == DCNT_W'(PIPE_DEPTH - 2));

`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
    // Reuse is only honoured once a full kernel has been shifted in since reset.
    logic kernel_loaded_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            kernel_loaded_q <= 1'b0;
        else if (state_q == LOAD && bus.k_valid && k_last)
            kernel_loaded_q <= 1'b1;
    end
    assign reuse_ok = bus.cfg_reuse_kernel && kernel_loaded_q;
`else
    assign reuse_ok = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = reuse_ok ? RUN : LOAD;
            LOAD:    if (bus.k_valid && k_last) state_d = RUN;
            RUN:     if (bus.win_valid && w_last) state_d = DRAIN;
            DRAIN:   if (d_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_ready   = 1'b0;
        win_ready = 1'b0;
        mult_run  = 1'b0;
        case (state_q)
            LOAD:  k_ready = 1'b1;
            RUN: begin
                win_ready = 1'b1;
                mult_run  = bus.win_valid;
            end
            DRAIN: mult_run = 1'b1;
            default: ;
        endcase
        kernel_run = k_ready && bus.k_valid;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_cnt_q     <= '0;
            win_cnt_q   <= '0;
            num_win_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_ok) begin
                    num_win_q   <= bus.cfg_num_windows;
                    k_cnt_q     <= '0;
                    win_cnt_q   <= '0;
                    drain_cnt_q <= '0;
                end
                LOAD:  if (kernel_run) k_cnt_q <= k_cnt_q + KCNT_W'(1);
                RUN:   if (mult_run) win_cnt_q <= win_cnt_q + WIN_CNT_W'(1);
                DRAIN: drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
                default: ;
            endcase
        end
    end

    // Tag stages 1..PIPE_DEPTH-1 live in tag_p; stage PIPE_DEPTH is psum_valid_q itself,
    // which only holds for the cycle after the edge the tag arrives on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_p        <= '0;
            psum_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            psum_valid_q <= mult_run && tag_p[TAG_W-1];
            if (mult_run)
                tag_p <= TAG_W'({tag_p, (state_q == RUN)});
        end
    end

    assign bus.k_ready    = k_ready;
    assign bus.kernel_run = kernel_run;
    assign bus.win_ready  = win_ready;
    assign bus.mult_run   = mult_run;
    assign bus.psum_valid = psum_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_cpe_mult_ctrl.sv
// Scoreboard bench for cpe_mult_ctrl: expected psum tags queued on window accept, retired on mult_run edges.
module tb_cpe_mult_ctrl;
    localparam int KS = 3;
    localparam int PD = 5;
    localparam int WW = 16;
    localparam int K2 = KS * KS;

    // expected-output encodings {k_ready, kernel_run, win_ready, mult_run, busy, done}
    localparam logic [5:0] E_IDLE  = 6'b000000;
    localparam logic [5:0] E_LGAP  = 6'b100010;
    localparam logic [5:0] E_LWORD = 6'b110010;
    localparam logic [5:0] E_RSTL  = 6'b001010;
    localparam logic [5:0] E_RACC  = 6'b001110;
    localparam logic [5:0] E_DRAIN = 6'b000110;
    localparam logic [5:0] E_DONE  = 6'b000011;

    logic clock = 1'b0;
    logic reset;

    cpe_mult_ctrl_if #(.WIN_CNT_W(WW)) bus_if ();

    cpe_mult_ctrl #(.KERNEL_SIZE(KS), .PIPE_DEPTH(PD), .WIN_CNT_W(WW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_q[$];
    logic exp_psum = 1'b0;
    int   psum_seen = 0;
    int   cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus_if.k_ready, bus_if.kernel_run, bus_if.win_ready, bus_if.mult_run,
                bus_if.busy, bus_if.done, bus_if.psum_valid};
    endfunction

    task automatic idle_in();
        bus_if.cfg_start       = 1'b0;
        bus_if.cfg_num_windows = '0;
`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
        bus_if.cfg_reuse_kernel = 1'b0;
`endif
        bus_if.k_valid   = 1'b0;
        bus_if.win_valid = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the scoreboard at the rising edge.
    task automatic step(input string tag, input logic [5:0] exp6);
        @(negedge clock);
        check_eq(tag, 32'(outs()), 32'({exp6, exp_psum}));
        if (bus_if.psum_valid) psum_seen++;
        @(posedge clock);
        exp_psum = 1'b0;
        if (exp6[2]) begin
            foreach (exp_q[i]) exp_q[i] = exp_q[i] - 1;
            if (exp_q.size() > 0 && exp_q[0] == 0) begin
                void'(exp_q.pop_front());
                exp_psum = 1'b1;
            end
        end
        if (exp6[3] && bus_if.win_valid) exp_q.push_back(PD - 1);
        cyc++;
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_psum = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must drop before the next clock edge.
    task automatic abort_cycle(input string tag, input logic [5:0] exp6);
        @(negedge clock);
        check_eq(tag, 32'(outs()), 32'({exp6, exp_psum}));
        #2 reset = 1'b1;
        #1 check_eq("async_rst", 32'(outs()), 32'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        cyc++;
        clear_model();
        idle_in();
        bus_if.k_valid   = 1'b1;
        bus_if.win_valid = 1'b1;
        for (int i = 0; i < PD + 1; i++) step("post_rst", E_IDLE);
        idle_in();
    endtask

    task automatic run_pass(input int n, input logic [15:0] kgap, input int stall_win,
                            input int stall_len, input bit noise, input bit reuse,
                            input bit exp_skip, input int abort_ph, input int abort_idx);
        int s;
        int exp_len;
        s = cyc;
        psum_seen = 0;
        bus_if.cfg_start       = 1'b1;
        bus_if.cfg_num_windows = WW'(n);
`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
        bus_if.cfg_reuse_kernel = reuse;
`endif
        step("start", E_IDLE);
        idle_in();
        if (!exp_skip) begin
            for (int w = 0; w < K2; w++) begin
                bus_if.win_valid = noise;
                if (kgap[w]) begin
                    bus_if.k_valid = 1'b0;
                    step("load_gap", E_LGAP);
                end
                bus_if.k_valid = 1'b1;
                step("load", E_LWORD);
            end
            idle_in();
        end
        for (int w = 0; w < n; w++) begin
            if (w == stall_win) begin
                for (int j = 0; j < stall_len; j++) begin
                    bus_if.win_valid = 1'b0;
                    bus_if.k_valid   = noise;
                    step("run_stall", E_RSTL);
                end
            end
            bus_if.win_valid       = 1'b1;
            bus_if.k_valid         = 1'b0;
            bus_if.cfg_start       = noise;
            bus_if.cfg_num_windows = noise ? WW'(7) : WW'(0);
            if (abort_ph == 1 && abort_idx == w) begin
                abort_cycle("run_abort", E_RACC);
                return;
            end
            step("run", E_RACC);
            idle_in();
        end
        idle_in();
        for (int d = 0; d < PD - 1; d++) begin
            if (abort_ph == 2 && abort_idx == d) begin
                abort_cycle("drain_abort", E_DRAIN);
                return;
            end
            step("drain", E_DRAIN);
        end
        step("done", E_DONE);
        step("after", E_IDLE);
        exp_len = 1 + (exp_skip ? 0 : K2 + $countones(kgap)) + n
                  + ((stall_win >= 0 && stall_win < n) ? stall_len : 0) + (PD - 1) + 1;
        check_eq("pass_len", 32'(cyc - 1 - s), 32'(exp_len));
        check_eq("psum_cnt", 32'(psum_seen), 32'(n));
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_vals", 32'(outs()), 32'(0));
        reset = 1'b0;
        step("idle", E_IDLE);

        // zero-window request must leave the controller idle
        bus_if.cfg_start       = 1'b1;
        bus_if.cfg_num_windows = '0;
        step("zero_req", E_IDLE);
        idle_in();
        step("zero_idle", E_IDLE);
        step("zero_idle2", E_IDLE);

        // nominal pass: 9 words, 4 windows, 19 cycles
        run_pass(4, 16'h0000, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        // kernel gaps, 2-cycle window stall, stray requests/valids
        run_pass(3, 16'h0025, 1, 2, 1'b1, 1'b0, 1'b0, 0, 0);
        // reset mid-RUN, then mid-DRAIN with two windows still in flight
        run_pass(4, 16'h0000, -1, 0, 1'b0, 1'b0, 1'b0, 1, 2);
        run_pass(3, 16'h0000, -1, 0, 1'b0, 1'b0, 1'b0, 2, 2);
        run_pass(4, 16'h0000, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_pass(1, 16'h0100, -1, 0, 1'b1, 1'b0, 1'b0, 0, 0);

`ifdef CPE_MULT_CTRL_KERNEL_REUSE_EN
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        clear_model();
        step("reuse_idle", E_IDLE);
        run_pass(2, 16'h0000, -1, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_pass(2, 16'h0000, -1, 0, 1'b0, 1'b1, 1'b1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
